// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receive path that feeds the byte FIFO.
//
//   Contents:
//     UART_DATA_BITS - payload bits per frame (8)
//     rx_state_t     - receiver FSM states
//     even_parity()  - parity bit value that makes the total count of ones
//                      across data and parity even
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// ---------------------------------------------------------------------------
// rx_sync
//   Two-flop synchronizer for the asynchronous serial line. Both flops reset
//   to 1 so the synchronized line reads idle (high) while in reset.
//
//   Ports:
//     i_clk   - clock
//     i_rst_n - asynchronous active-low reset
//     i_d     - asynchronous input
//     o_q     - synchronized output (two clocks of latency)
// ---------------------------------------------------------------------------
module rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx_fifo_wr.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_wr
//   UART receiver (8 data bits, LSB first, 1 stop bit) that writes each good
//   byte into the downstream 16-deep FIFO as a single-cycle write pulse.
//   Owns bit timing, start-bit validation, stop-bit checking and overflow
//   reporting.
//
//   Build option:
//     UART_RX_PARITY_EN - adds an even-parity bit after the data bits and the
//                         parity_err output. Undefined: plain 8N1.
//
//   Parameters:
//     CLKS_PER_BIT - clocks per serial bit (>= 4)
//
//   Ports:
//     clk        - clock, all logic on posedge
//     rst        - asynchronous active-low reset
//     rx         - serial line, idle high, asynchronous to clk
//     full       - FIFO full flag, looked at only on the write decision
//     wr         - one-cycle FIFO write strobe
//     din        - received byte, valid with wr, held until the next write
//     busy       - receiver not in IDLE
//     frame_err  - one-cycle pulse: stop bit sampled low
//     overrun    - one-cycle pulse: good byte arrived while full, dropped
//     parity_err - (UART_RX_PARITY_EN only) one-cycle pulse: parity mismatch
//                  with a good stop bit, byte dropped
// ---------------------------------------------------------------------------
module uart_rx_fifo_wr
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       full,
    output logic       wr,
    output logic [7:0] din,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);
    localparam logic [2:0]    BIT_LAST      = 3'(UART_DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    rx_state_t                   r_state;
    logic [CW-1:0]               r_cnt;
    logic [2:0]                  r_bit;
    logic [UART_DATA_BITS-1:0]   r_shift;
    logic [1:0]                  r_flush;
    logic                        r_rx_prev;
    logic                        r_wr;
    logic [UART_DATA_BITS-1:0]   r_din;
    logic                        r_frame_err;
    logic                        r_overrun;
`ifdef UART_RX_PARITY_EN
    logic                        r_par_bad;
    logic                        r_parity_err;
`endif

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic                        w_rx_s;
    logic                        w_fall;
    logic                        w_bit_tick;
    logic                        w_half_tick;
    logic                        w_par_bad;
    rx_state_t                   w_state_nxt;
    logic [CW-1:0]               w_cnt_nxt;
    logic [2:0]                  w_bit_nxt;
    logic [UART_DATA_BITS-1:0]   w_shift_nxt;
    logic                        w_wr_nxt;
    logic [UART_DATA_BITS-1:0]   w_din_nxt;
    logic                        w_frame_err_nxt;
    logic                        w_overrun_nxt;
`ifdef UART_RX_PARITY_EN
    logic                        w_par_bad_nxt;
    logic                        w_parity_err_nxt;
`endif

    rx_sync u_rx_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     (rx),
        .o_q     (w_rx_s)
    );

    // r_rx_prev is forced low until the synchronizer has flushed its reset
    // ones, so a line already low at reset release is never mistaken for a
    // falling edge; a real high must be seen first.
    assign w_fall      = r_rx_prev & ~w_rx_s;
    assign w_bit_tick  = (r_cnt == CNT_BIT_LAST);
    assign w_half_tick = (r_cnt == CNT_HALF_LAST);

`ifdef UART_RX_PARITY_EN
    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_flush      <= '0;
            r_rx_prev    <= 1'b0;
            r_wr         <= 1'b0;
            r_din        <= '0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit        <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_flush      <= {r_flush[0], 1'b1};
            r_rx_prev    <= r_flush[1] ? w_rx_s : 1'b0;
            r_wr         <= w_wr_nxt;
            r_din        <= w_din_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_overrun    <= w_overrun_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= w_par_bad_nxt;
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_bit_nxt        = r_bit;
        w_shift_nxt      = r_shift;
        w_wr_nxt         = 1'b0;
        w_din_nxt        = r_din;
        w_frame_err_nxt  = 1'b0;
        w_overrun_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt    = r_par_bad;
        w_parity_err_nxt = 1'b0;
`endif

        unique case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = '0;
                end
            end

            START: begin
                if (w_half_tick) begin
                    w_cnt_nxt = '0;
                    if (!w_rx_s) begin
                        w_state_nxt = DATA;
                        w_bit_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            DATA: begin
                if (w_bit_tick) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_bit_tick) begin
                    w_cnt_nxt     = '0;
                    w_par_bad_nxt = (w_rx_s != even_parity(r_shift));
                    w_state_nxt   = STOP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
`endif

            STOP: begin
                if (w_bit_tick) begin
                    w_cnt_nxt = '0;
                    if (!w_rx_s) begin
                        // Framing error takes precedence over parity.
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = BREAK;
                    end else begin
                        // Leave at mid-stop-bit so a fast transmitter's next
                        // start edge is not missed.
                        w_state_nxt = IDLE;
                        if (w_par_bad) begin
`ifdef UART_RX_PARITY_EN
                            w_parity_err_nxt = 1'b1;
`endif
                        end else if (full) begin
                            w_overrun_nxt = 1'b1;
                        end else begin
                            w_wr_nxt  = 1'b1;
                            w_din_nxt = r_shift;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr        = r_wr;
    assign din       = r_din;
    assign busy      = (r_state != IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo_wr
//   Drives serial frames into uart_rx_fifo_wr with a 16-deep FIFO model on
//   its write port. Each frame's outcome (write, overrun, framing or parity
//   error) and its arrival cycle are predicted when the frame is launched and
//   queued; a monitor pops and compares whenever the DUT pulses an output.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo_wr;

    localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // Serial bits after the start bit up to and including the stop bit.
    localparam int unsigned NSAMP = PAR_EN ? 10 : 9;

    localparam int K_WR   = 0;
    localparam int K_OVR  = 1;
    localparam int K_FERR = 2;
    localparam int K_PERR = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        longint     cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       full;
    logic       wr;
    logic [7:0] din;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int         checks;
    int         errors;
    longint     cyc;

    exp_t       sb_q[$];
    logic [7:0] exp_fifo[$];
    logic [7:0] exp_din;

    logic [7:0] fifo_q[$];
    logic       rd_req;
    logic [7:0] rd_data;

    uart_rx_fifo_wr #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .full       (full),
        .wr         (wr),
        .din        (din),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // FIFO model: 16 entries, ignores writes when full.
    initial begin
        full    = 1'b0;
        rd_data = '0;
    end
    always @(negedge clk) begin
        if (rd_req && fifo_q.size() > 0) rd_data = fifo_q.pop_front();
        if (wr && fifo_q.size() < 16) fifo_q.push_back(din);
        full = (fifo_q.size() >= 16);
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        int   n;
        exp_t e;
        int   k;
        if (!rst) begin
            exp_din = 8'h00;
        end else begin
            n = int'(wr) + int'(overrun) + int'(frame_err) + int'(parity_err);
            if (n > 0) begin
                check("pulse_onehot", n, 1);
                k = wr ? K_WR : overrun ? K_OVR : frame_err ? K_FERR : K_PERR;
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse_kind", k, -1);
                end else begin
                    e = sb_q.pop_front();
                    check("pulse_kind", k, e.kind);
                    check("pulse_cycle", cyc, e.cyc);
                    if (e.kind == K_WR) begin
                        check("wr_din", din, e.data);
                        exp_din = e.data;
                    end else begin
                        check("din_hold", din, exp_din);
                    end
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Launch one frame; the outcome is predicted from the framing rules and
    // the expected FIFO occupancy at the moment of the stop bit.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
        exp_t e;
        e.data = d;
        // rx falls before the next posedge (cyc+1); 2 sync cycles, half a bit,
        // NSAMP full bits to the stop sample, output visible after that edge.
        e.cyc = cyc + 1 + 2 + CPB / 2 + NSAMP * CPB;
        if (!stop_ok) e.kind = K_FERR;
        else if (PAR_EN && !par_ok) e.kind = K_PERR;
        else if (exp_fifo.size() >= 16) e.kind = K_OVR;
        else begin
            e.kind = K_WR;
            exp_fifo.push_back(d);
        end
        sb_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par_ok ? ^d : ~^d);
        drive_bit(stop_ok);
    endtask

    task automatic wait_sb();
        int unsigned n;
        n = 0;
        while (sb_q.size() > 0 && n < 4 * NSAMP * CPB) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", sb_q.size(), 0);
    endtask

    task automatic fifo_pop(output logic [7:0] d);
        @(posedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        #1;
        rd_req = 1'b0;
        d = rd_data;
    endtask

    task automatic drain();
        logic [7:0] d;
        wait_sb();
        while (exp_fifo.size() > 0) begin
            fifo_pop(d);
            check("fifo_rd", d, exp_fifo.pop_front());
        end
        check("fifo_empty", fifo_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr"}, wr, 0);
        check({tag, "_din"}, din, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_parity_err"}, parity_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, pending %0d", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         s_ok;
        bit         p_ok;
        checks  = 0;
        errors  = 0;
        exp_din = 8'h00;
        rst     = 1'b0;
        rx      = 1'b1;
        rd_req  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        idle(5);

        // Single byte.
        send_frame(8'h55, 1'b1, 1'b1);
        idle(3);
        drain();

        // Glitch shorter than half a bit, then a real byte.
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(CPB);
        check("glitch_busy", busy, 0);
        send_frame(8'hA3, 1'b1, 1'b1);
        idle(3);
        drain();

        // Framing error followed by a held-low line.
        send_frame(8'h3C, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check("break_busy", busy, 1);
        idle(4);
        check("break_exit_busy", busy, 0);
        send_frame(8'h81, 1'b1, 1'b1);
        idle(3);
        drain();

        // Overrun against a full FIFO.
        for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1, 1'b1);
        idle(3);
        wait_sb();
        check("prefill_size", fifo_q.size(), 16);
        send_frame(8'h7E, 1'b1, 1'b1);
        idle(3);
        wait_sb();
        check("overrun_size", fifo_q.size(), 16);
        for (int i = 0; i < 16; i++) check("overrun_contents", fifo_q[i], exp_fifo[i]);
        fifo_pop(d);
        check("fifo_rd", d, exp_fifo.pop_front());
        send_frame(8'h7F, 1'b1, 1'b1);
        idle(3);
        drain();

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h12, 1'b1, 1'b1);
        idle(3);
        drain();

        // Reset during data bit 4.
        d = 8'h96;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("low_after_reset_busy", busy, 0);
        idle(4);
        send_frame(8'h96, 1'b1, 1'b1);
        idle(3);
        if (PAR_EN) begin
            send_frame(8'h96, 1'b1, 1'b0);
            idle(3);
        end
        drain();

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            d    = 8'($urandom);
            s_ok = ($urandom_range(0, 9) != 0);
            p_ok = ($urandom_range(0, 9) != 0);
            send_frame(d, s_ok, p_ok);
            if (!s_ok) idle($urandom_range(2, 6));
            else idle($urandom_range(0, 3));
            if (exp_fifo.size() >= 12) drain();
        end
        idle(3);
        drain();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
